fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/mips_pkg.sv | 15 +
 rtl/pc_next_logic.sv | 32 +++
 rtl/fetch_sequencer.sv | 84 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage constants: sequencer state codes, SYSCALL opcode word, default reset PC.
package mips_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [31:0] SYSCALL          = 32'h0000_000C;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC candidates for the fetch sequencer: wrapping sequential increment and
// aligned redirect target (branch wins over jump).
module pc_next_logic
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    output logic [31:0] seq_pc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        target_misaligned
);

    localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * (MEM_WORDS - 1));

    logic [31:0] raw_target;

    always_comb begin
        seq_pc            = (pc == LAST_PC) ? RESET_PC : pc + 32'd4;
        redirect          = branch_taken | jump_taken;
        raw_target        = branch_taken ? branch_target : jump_target;
        redirect_pc       = word_align(raw_target);
        target_misaligned = (raw_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: BOOT/RUN/HALT FSM, PC register and fetch output registers.
// Optional FETCH_HALT_EN: a fetched SYSCALL word parks the sequencer in HALT until reset.
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    output logic [31:0] Address,
    input  logic [31:0] InstrIn,
    output logic [31:0] InstrOut,
    output logic        InstrValid,
    output logic [31:0] PCOut,
    output logic        Misaligned,
    output logic [15:0] FetchCount
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] seq_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        target_misaligned;

    pc_next_logic #(
        .RESET_PC  (RESET_PC),
        .MEM_WORDS (MEM_WORDS)
    ) u_pc_next (
        .pc                (pc),
        .branch_taken      (BranchTaken),
        .branch_target     (BranchTarget),
        .jump_taken        (JumpTaken),
        .jump_target       (JumpTarget),
        .seq_pc            (seq_pc),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .target_misaligned (target_misaligned)
    );

    assign Address = pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_BOOT;
            pc         <= RESET_PC;
            InstrOut   <= '0;
            PCOut      <= '0;
            InstrValid <= 1'b0;
            Misaligned <= 1'b0;
            FetchCount <= '0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    // Redirect squashes the word currently on InstrIn even while stalled.
                    if (redirect) begin
                        pc         <= redirect_pc;
                        InstrValid <= 1'b0;
                        if (target_misaligned) Misaligned <= 1'b1;
                    end else if (!Stall) begin
                        InstrOut   <= InstrIn;
                        PCOut      <= pc;
                        InstrValid <= 1'b1;
                        pc         <= seq_pc;
                        if (FetchCount != 16'hFFFF) FetchCount <= FetchCount + 16'd1;
`ifdef FETCH_HALT_EN
                        if (InstrIn == SYSCALL) state <= ST_HALT;
`endif
                    end
                end
                ST_HALT: InstrValid <= 1'b0;
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule
